// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared definitions for the BCD-to-binary converter.
//
// Holds the converter FSM encoding, the BCD digit width, the digit
// adjustment constants used by reverse double-dabble, the iteration count
// and a digit-validity helper used when BCD_BIN_ERRCHK_EN is defined.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIG_W         = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int ADJ_THRESH    = 8;
    localparam int ADJ_SUB       = 3;
    localparam int N_ITER        = 10;

    // True when a 4-bit BCD digit holds a code above 9.
    function automatic logic digit_invalid(input logic [DIG_W-1:0] d);
        return d > DIG_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj -- one-digit correction step of reverse double-dabble.
//
// Ports:
//   din  [3:0] : digit after the right shift
//   dout [3:0] : din - 3 when din >= 8, else din (purely combinational)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    // A digit >= 8 after a right shift means a borrow of ten came in from
    // the digit above; subtracting 3 turns the binary half (8) into the
    // decimal half (5).
    always_comb begin
        if (din >= DIG_W'(ADJ_THRESH)) begin
            dout = din - DIG_W'(ADJ_SUB);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bcd_bin12.sv
// bcd_bin12 -- sequential 3-digit BCD to 10-bit binary converter.
//
// Converts by reverse double-dabble, one result bit per clock: the packed
// {digits, result} register shifts right by one and every digit >= 8 has 3
// subtracted. Ten iterations produce the binary value.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : conversion request, sampled only in IDLE (no queuing)
//   bcd    : packed digits {hundreds, tens, units}, captured with start
//   bin    : registered result, updated on entry to DONE, held until next
//   busy   : high in CONV and DONE
//   done   : one-cycle pulse, 11 rising edges after the accepting edge
//   err    : invalid-digit flag, valid with done
//
// Handshake: start is a request without back-pressure; it is taken only on
// an edge where the FSM is in IDLE and dropped otherwise. done is a
// single-cycle strobe with no acknowledge; bin/err stay valid until the
// next conversion completes.
//
// Optional: define BCD_BIN_ERRCHK_EN to flag digits above 9 (err = 1,
// bin = 0). Without it err is tied low and no checking logic exists.
module bcd_bin12
    import bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int NBIN = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NDIG*DIG_W-1:0] bcd,
    output logic [NBIN-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DW = NDIG * DIG_W;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [NBIN-1:0]   res_q, res_d;
    logic [NBIN-1:0]   bin_q, bin_d;
    logic              done_q, done_d;

    logic [DW-1:0]     dig_shift;
    logic [DW-1:0]     dig_adj;
    logic [NBIN-1:0]   res_shift;

    // One iteration: the digit LSB falls into the result MSB.
    assign dig_shift = {1'b0, dig_q[DW-1:1]};
    assign res_shift = {dig_q[0], res_q[NBIN-1:1]};

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_shift[g*DIG_W +: DIG_W]),
            .dout (dig_adj[g*DIG_W +: DIG_W])
        );
    end

`ifdef BCD_BIN_ERRCHK_EN
    logic bad_q, bad_d;
    logic err_q, err_d;

    always_comb begin
        bad_d = bad_q;
        err_d = err_q;
        if (state_q == IDLE && start) begin
            bad_d = 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                if (digit_invalid(bcd[i*DIG_W +: DIG_W])) begin
                    bad_d = 1'b1;
                end
            end
        end
        if (state_q == CONV && cnt_q == 4'(N_ITER - 1)) begin
            err_d = bad_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        res_d   = res_q;
        bin_d   = bin_q;
        // done is registered from DONE, giving the 11-edge latency and
        // leaving the pulse aligned with the return to IDLE.
        done_d  = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    cnt_d   = 4'd0;
                    dig_d   = bcd;
                    res_d   = '0;
                end
            end
            CONV: begin
                dig_d = dig_adj;
                res_d = res_shift;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(N_ITER - 1)) begin
                    state_d = DONE;
`ifdef BCD_BIN_ERRCHK_EN
                    bin_d = bad_q ? '0 : res_shift;
`else
                    bin_d = res_shift;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dig_q   <= '0;
            res_q   <= '0;
            bin_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            res_q   <= res_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
        end
    end

    assign bin  = bin_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_bcd_bin12.sv
// tb_bcd_bin12 -- directed self-checking bench for bcd_bin12.
module tb_bcd_bin12;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    bcd_bin12 #(.NDIG(3), .NBIN(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, scramble bcd after the accepting edge, wait for
    // done (bounded) and return bin/err and the edge count to done.
    task automatic run_conv(input logic [11:0] v, output logic [9:0] b,
                            output logic e, output int lat);
        @(negedge clk);
        start = 1'b1;
        bcd   = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bcd   = 12'($urandom_range(0, 4095));
        lat   = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        b = bin;
        e = err;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    logic [9:0] r_bin;
    logic       r_err;
    int         r_lat;
    int         n_done;
    int         done_at[$];

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        bcd   = 12'h000;

        // reset behaviour
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err",  {31'd0, err},  32'd0);
        check("rst_bin",  {22'd0, bin},  32'd0);
        start = 1'b1;
        bcd   = 12'h999;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy_clocked", {31'd0, busy}, 32'd0);
        check("rst_done_clocked", {31'd0, done}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // maximum value and latency
        run_conv(12'h999, r_bin, r_err, r_lat);
        check("lat_999", r_lat, 32'd11);
        check("bin_999", {22'd0, r_bin}, 32'h3E7);
        check("err_999", {31'd0, r_err}, 32'd0);

        // busy right after accept
        @(negedge clk);
        start = 1'b1;
        bcd   = 12'h519;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_conv", {31'd0, busy}, 32'd1);
        check("bin_hold_999", {22'd0, bin}, 32'h3E7);
        r_lat = 0;
        while (r_lat < 40) begin
            @(posedge clk);
            r_lat++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("lat_519", r_lat, 32'd11);
        check("bin_519", {22'd0, bin}, 32'h207);
        repeat (2) @(negedge clk);

        // start held every cycle: only 12-cycle spaced accepts
        n_done = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (cyc == 6) check("bin_hold_519", {22'd0, bin}, 32'h207);
            if (cyc == 1) check("busy_burst", {31'd0, busy}, 32'd1);
            if (done === 1'b1) begin
                n_done++;
                done_at.push_back(cyc);
                check("bin_burst", {22'd0, bin}, 32'h07B);
            end
            start = (cyc < 30);
            bcd   = 12'h123;
        end
        start = 1'b0;
        check("burst_done_count", n_done, 32'd3);
        if (done_at.size() == 3) begin
            check("burst_done0", done_at[0], 32'd12);
            check("burst_done1", done_at[1], 32'd24);
            check("burst_done2", done_at[2], 32'd36);
        end

        run_conv(12'h000, r_bin, r_err, r_lat);
        check("bin_000", {22'd0, r_bin}, 32'h000);
        check("lat_000", r_lat, 32'd11);

        // reset during conversion
        @(negedge clk);
        start = 1'b1;
        bcd   = 12'h456;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bin",  {22'd0, bin},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 32'd0);
        run_conv(12'h456, r_bin, r_err, r_lat);
        check("bin_456", {22'd0, r_bin}, 32'h1C8);
        check("lat_456", r_lat, 32'd11);

`ifdef BCD_BIN_ERRCHK_EN
        run_conv(12'h1A3, r_bin, r_err, r_lat);
        check("err_1A3", {31'd0, r_err}, 32'd1);
        check("bin_1A3", {22'd0, r_bin}, 32'd0);
        check("lat_1A3", r_lat, 32'd11);
`endif
        run_conv(12'h013, r_bin, r_err, r_lat);
        check("err_013", {31'd0, r_err}, 32'd0);
        check("bin_013", {22'd0, r_bin}, 32'h00D);

        // full sweep against arithmetic reference
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int u = 0; u < 10; u++) begin
                    logic [11:0] v;
                    logic [9:0]  exp_bin;
                    v       = {h[3:0], t[3:0], u[3:0]};
                    exp_bin = 10'(h * 100 + t * 10 + u);
                    run_conv(v, r_bin, r_err, r_lat);
                    check("sweep_bin", {22'd0, r_bin}, {22'd0, exp_bin});
                    check("sweep_err", {31'd0, r_err}, 32'd0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
